// File: rtl/fp_divider_seq.sv
// Sequential IEEE 754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, denormals flushed to zero.
module fp_divider_seq #(
    parameter int          QBITS = 27,
    parameter logic [31:0] QNAN  = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM_ROUND, DONE} state_t;

    localparam logic [4:0] LAST = 5'(QBITS - 1);

    state_t             state;
    logic [4:0]         cnt;
    logic [24:0]        rem;
    logic [23:0]        dvs;
    logic [QBITS-1:0]   quo;
    logic signed [9:0]  exp_r;
    logic               sign_r;

    // Increment the 24-bit significand when RNE demands it; returns {carry, fraction}.
    // A carry only happens from all-ones, and then the wrapped fraction is already 0 (1.0).
    function automatic logic [23:0] round_rne(input logic [23:0] m, input logic g, input logic s);
        logic inc;
        inc = g & (s | m[0]);
        return {inc & (&m), m[22:0] + {22'd0, inc}};
    endfunction

    // Operand classification for the accept-cycle special-case decision
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_q;
    logic        is_special;
    logic [31:0] spec_result;
    logic [3:0]  spec_flags;

    always_comb begin
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        sign_q = a[31] ^ b[31];
        is_special  = 1'b1;
        spec_result = 32'd0;
        spec_flags  = 4'd0;
        if (a_nan || b_nan) begin
            spec_result = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result = QNAN;
            spec_flags  = 4'b1000;
        end else if (b_zero && !a_inf) begin
            spec_result = {sign_q, 8'hFF, 23'd0};
            spec_flags  = 4'b0100;
        end else if (a_inf) begin
            spec_result = {sign_q, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            spec_result = {sign_q, 31'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    logic [24:0] diff;
    logic        rem_ge;
    assign diff   = rem - {1'b0, dvs};
    assign rem_ge = (rem >= {1'b0, dvs});

    // Normalisation and rounding of the finished quotient
    logic [23:0]       mant_pre;
    logic              guard, sticky;
    logic signed [9:0] exp_adj, exp_fin;
    logic [23:0]       rnd;
    logic [31:0]       nr_result;
    logic              nr_ovf, nr_unf;

    always_comb begin
        if (quo[26]) begin
            mant_pre = quo[26:3];
            guard    = quo[2];
            sticky   = (|quo[1:0]) | (|rem);
            exp_adj  = exp_r;
        end else begin
            mant_pre = quo[25:2];
            guard    = quo[1];
            sticky   = quo[0] | (|rem);
            exp_adj  = exp_r - 10'sd1;
        end
        rnd     = round_rne(mant_pre, guard, sticky);
        exp_fin = exp_adj + $signed({9'd0, rnd[23]});
        nr_ovf  = 1'b0;
        nr_unf  = 1'b0;
        if (exp_fin >= 10'sd255) begin
            nr_result = {sign_r, 8'hFF, 23'd0};
            nr_ovf    = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            nr_result = {sign_r, 31'd0};
            nr_unf    = 1'b1;
        end else begin
            nr_result = {sign_r, exp_fin[7:0], rnd[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            rem         <= 25'd0;
            dvs         <= 24'd0;
            quo         <= '0;
            exp_r       <= 10'sd0;
            sign_r      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'd0;
            {invalid, div_by_zero, overflow, underflow} <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        sign_r <= sign_q;
                        if (is_special) begin
                            result <= spec_result;
                            {invalid, div_by_zero, overflow, underflow} <= spec_flags;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            rem   <= {2'b01, a[22:0]};
                            dvs   <= {1'b1, b[22:0]};
                            exp_r <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                            quo   <= '0;
                            cnt   <= 5'd0;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= rem_ge ? (diff << 1) : (rem << 1);
                    quo   <= {quo[QBITS-2:0], rem_ge};
                    cnt   <= cnt + 5'd1;
                    if (cnt == LAST)
                        state <= NORM_ROUND;
                end
                NORM_ROUND: begin
                    result <= nr_result;
                    {invalid, div_by_zero, overflow, underflow} <= {2'b00, nr_ovf, nr_unf};
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Scoreboard bench for fp_divider_seq: expected quotient/flags queued at issue,
// compared when done pulses; latency and handshake checked by the driver.
module tb_fp_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic        invalid, div_by_zero, overflow, underflow;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fp_divider_seq dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .invalid(invalid), .div_by_zero(div_by_zero),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("result", result, e.res);
                check_val("flags", {28'd0, invalid, div_by_zero, overflow, underflow}, {28'd0, e.flg});
            end
        end
    end

    // Wait for done from the first cycle after accept; returns cycles counted.
    task automatic wait_done(output int cycles, output bit busy_ok);
        cycles  = 1;
        busy_ok = 1'b1;
        while (!done && cycles < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] res, input logic [3:0] flg, input int lat);
        int cyc;
        bit bok;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        sb.push_back('{res: res, flg: flg});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
        wait_done(cyc, bok);
        check_val({tag, "_latency"}, cyc, lat);
        check_val({tag, "_busy"}, {31'd0, bok}, 32'd1);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit bok;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_out", {result[31:6], busy, done, invalid, div_by_zero, overflow, underflow},
                  32'd0);
        check_val("reset_result", result, 32'd0);
        rst = 1'b0;

        run_op("half",      32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 29);
        run_op("third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
        run_op("m2_3",      32'hBF800000, 32'h3FC00000, 32'hBF2AAAAB, 4'b0000, 29);
        run_op("tenth",     32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 4'b0000, 29);
        run_op("m8_2",      32'hC1000000, 32'h40000000, 32'hC0800000, 4'b0000, 29);
        run_op("six_3",     32'h40C00000, 32'h40400000, 32'h40000000, 4'b0000, 29);
        run_op("one_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        run_op("mone_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1);
        run_op("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_op("inf_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1);
        run_op("zero_two",  32'h00000000, 32'h40000000, 32'h00000000, 4'b0000, 1);
        run_op("nan",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
        run_op("inf_m2",    32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1);
        run_op("one_inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 1);
        run_op("ovf",       32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 29);
        run_op("unf",       32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 29);
        run_op("denorm",    32'h80000001, 32'h3F800000, 32'h80000000, 4'b0000, 1);

        // Start held high with operands changing during busy
        @(negedge clk);
        a = 32'h40400000; b = 32'h3FC00000; start = 1'b1;
        sb.push_back('{res: 32'h40000000, flg: 4'b0000});
        @(posedge clk);
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000;
        wait_done(cyc, bok);
        check_val("hold_latency", cyc, 29);
        check_val("hold_busy", {31'd0, bok}, 32'd1);
        sb.push_back('{res: 32'h3EAAAAAB, flg: 4'b0000});
        @(negedge clk);
        check_val("hold_idle_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("hold_reaccept", {31'd0, busy}, 32'd1);
        wait_done(cyc, bok);
        check_val("hold2_latency", cyc, 29);
        @(negedge clk);

        // Reset in the middle of a divide
        a = 32'h3F800000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_mid_ctrl", {30'd0, busy, done}, 32'd0);
        check_val("rst_mid_result", result, 32'd0);
        check_val("rst_mid_flags", {28'd0, invalid, div_by_zero, overflow, underflow}, 32'd0);
        run_op("after_rst", 32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000, 29);

        repeat (3) @(negedge clk);
        check_val("sb_leftover", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_divider_seq.md
Name: fp_divider_seq

Overview:
- Iterative IEEE 754 single-precision divider (result = a / b); the inverse-operation companion to the combinational fp_multiplier.
- Produces one quotient bit per cycle using a restoring mantissa divider, with start/busy/done handshake.
- Rounds to nearest, ties to even.
- Flushes denormals (inputs and outputs) to signed zero.
- Sits in the FP datapath beside the multiplier; the controller issues an operation and waits for done.

Parameters:
- QBITS, 27, number of quotient bits generated: 1 integer bit, 23 fraction bits, guard bit, 2 extra bits. Fixed by the datapath; do not override.
- QNAN, 32'h7FC00000, canonical NaN returned for every NaN result.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend, IEEE 754 single
- b  input  32  divisor, IEEE 754 single
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when result is valid
- result  output  32  quotient; held until the next accepted start
- invalid  output  1  set for 0/0 or inf/inf; held with result
- div_by_zero  output  1  set for finite nonzero / zero; held with result
- overflow  output  1  set when the result rounds to infinity; held with result
- underflow  output  1  set when the result is flushed to zero from a nonzero exact quotient; held with result

Behaviour:
- Reset: state=IDLE; busy, done, result, and all flags = 0; counter = 0.
- rst has priority over every other event. Reset mid-operation discards the in-flight operation; the state is IDLE the next cycle.
- States and transitions: IDLE -> (DIVIDE | DONE), DIVIDE -> NORM_ROUND -> DONE -> IDLE.
- Accept: start=1 in IDLE at posedge (call it cycle 0). On accept:
  - a and b are latched.
  - Operands with exponent 0 are treated as zero.
  - The special-case decision is made in this cycle.
  - On any new accept, result and flags clear only when the new result loads.
- Special cases, in priority order (result loaded at accept; state -> DONE; done=1 in cycle 1):
  - Either operand NaN: QNAN, no flag.
  - 0/0 or inf/inf: QNAN, invalid=1.
  - Finite nonzero / 0: signed inf, div_by_zero=1.
  - inf / finite: signed inf.
  - 0 / nonzero, or finite / inf: signed zero.
  - Sign = sign(a) XOR sign(b) for all non-NaN results.
- Normal path, latch on accept:
  - Remainder R = {1, frac_a}, 25 bits wide.
  - Divisor D = {1, frac_b}.
  - Exponent E = exp_a - exp_b + 127, computed as a 10-bit signed value.
- DIVIDE state, cycles 1..QBITS, one iteration per cycle:
  - If R >= D: q bit = 1 and R = R - D; otherwise q bit = 0.
  - Then shift: R = R << 1 and q = {q, bit}.
  - The counter runs 0..26; the transition to NORM_ROUND happens after the 27th bit.
- NORM_ROUND state, cycle 28:
  - If q[26]=1: mant = q[26:3], guard = q[2], sticky = |q[1:0] | (R != 0).
  - Otherwise: mant = q[25:2], guard = q[1], sticky = q[0] | (R != 0), and E = E - 1.
  - RNE: increment mant if guard & (sticky | mant[0]).
  - If the increment carries out of mant: mant = 1.0 and E = E + 1.
  - If E >= 255: result = signed inf, overflow=1.
  - If E <= 0: result = signed zero, underflow=1.
  - Otherwise result = {sign, E[7:0], mant[22:0]}.
- DONE state (cycle 29 normal, cycle 1 special):
  - done=1 and busy=1 for exactly this cycle.
  - The next cycle is IDLE, so a new start is accepted 1 cycle after done at the earliest.
- Latency from the accept edge to done: normal = 29 cycles, special = 1 cycle.
- start while busy is ignored; the latched operands do not change.
- a and b may change freely after the accept cycle.

Test Plan:
- 1/2: a=3F800000, b=40000000 -> result 3F000000. done pulses exactly 29 cycles after accept for one cycle; no flags.
- Rounding check: a=3F800000 (1), b=40400000 (3) -> 3EAAAAAB. a=BF800000, b=3FC00000 -> BF2AAAAB (-2/3, sign and RNE).
- Specials, each with done 1 cycle after accept:
  - 3F800000/00000000 -> 7F800000, div_by_zero=1.
  - 00000000/00000000 -> 7FC00000, invalid=1.
  - 7F800000/7F800000 -> 7FC00000, invalid=1.
  - 00000000/40000000 -> 00000000.
  - 7FC00001/3F800000 -> 7FC00000, no flags.
- Range limits:
  - 7F000000/00800000 -> 7F800000, overflow=1.
  - 00800000/7F000000 -> 00000000, underflow=1.
  - 80000001 (denormal)/3F800000 -> 80000000, no flags.
- Handshake:
  - Assert start with 40400000/3FC00000 (3/1.5); hold start high and change a and b during busy. Result must be 40000000, busy stays high through done, and the changed operands are not accepted until the cycle after done.
  - Assert rst at cycle 10 of a divide: next cycle busy=0, done=0, result=0, all flags=0. A following start completes normally.
